fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage, directly upstream of decode/execute. It owns the program counter, issues word-aligned requests to instruction memory under a req/ready handshake, and presents one instruction at a time with its PC to decode/execute. It consumes execute's branch redirect (exeOverride plus the 16-bit exeData offset): on a redirect it squashes the held instruction and refetches from the branch target.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
ADDR_W, 32, PC and imem address width.
INSTR_W, 32, instruction width.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous active-high reset.
exeOverride  in  1  branch taken; registered redirect request from execute.
exeData  in  16  signed branch word offset, relative to pc_out.
stall  in  1  downstream cannot accept a new instruction; hold instr_out/pc_out.
imem_req  out  1  fetch request valid.
imem_addr  out  ADDR_W  fetch byte address, word-aligned.
imem_ready  in  1  imem_rdata valid this cycle; meaningful only while imem_req=1.
imem_rdata  in  INSTR_W  fetched instruction.
instr_out  out  INSTR_W  instruction presented to decode.
pc_out  out  ADDR_W  byte address of instr_out.
instr_valid  out  1  instr_out/pc_out valid.

Behaviour:
- Reset (rst high at posedge) sets: fetch_pc=RESET_PC, state=IDLE, instr_valid=0, instr_out=0, pc_out=0. imem_req=0 and imem_addr=RESET_PC while in IDLE.
- States:
  - IDLE: exactly one cycle after rst deasserts, then FETCH.
  - FETCH: requesting.
  - REDIRECT: one bubble cycle after a taken branch, then FETCH.
- Definition: accept = !instr_valid || !stall.
- imem_req = (state==FETCH) && accept && !exeOverride (combinational). imem_addr = fetch_pc (registered).
- Handshake: imem_addr is stable while imem_req=1 and imem_ready=0. A transfer completes on a cycle with imem_req && imem_ready.
- On transfer, at the next edge: instr_out<=imem_rdata, pc_out<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+4.
  - Back-to-back transfers give 1 instruction/cycle.
  - Latency: 1 cycle from imem_ready to instr_valid.
- FETCH with no transfer and accept=1: instr_valid<=0 (bubble).
- FETCH with instr_valid=1 and stall=1: all outputs hold, imem_req=0.
- Redirect (exeOverride=1 at posedge) has top priority over stall, imem_ready and IDLE→FETCH:
  - fetch_pc<=pc_out + (sext32(exeData)<<2).
  - instr_valid<=0; state<=REDIRECT.
  - imem_rdata in the same cycle is discarded (imem_req is already 0).
- exeOverride during REDIRECT: re-target using the current pc_out (pc_out is held) and stay in REDIRECT.
- Arithmetic: all PC math is modulo 2^ADDR_W.
  - 32'hFFFF_FFFC+4 wraps to 0.
  - Targets are always word-aligned (offset shifted by 2); a negative offset below 0 wraps.
- rst mid-transfer or mid-stall: reset values win; any imem_ready in that cycle is ignored.
- imem_ready while imem_req=0 is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state enum {IDLE, FETCH, REDIRECT}
  - PC_INC=4
  - INSTR_W/ADDR_W defaults
  - RESET_PC default
- One sub-module, branch_target: combinational pc + (sext(off16)<<2) adder. Execute may reuse it later for PC-relative ops.

Test Plan:
- Reset, imem_ready tied 1, imem_rdata=addr^32'hA5A5_0000, RESET_PC=0: imem_req low during IDLE. Then addresses 0,4,8,C on consecutive cycles, each pc_out/instr_out one cycle later, instr_valid continuous.
- Memory wait states (imem_ready low 2 cycles per fetch): imem_addr held stable. Expect one instr_valid pulse per 3 cycles with correct pc_out sequence.
- stall high for 3 cycles while pc_out=8: instr_out/pc_out frozen and imem_req=0. After release, pc_out=C the next cycle, with no skipped or duplicated address.
- exeOverride with pc_out=0x10, exeData=16'hFFFC (-4): instr_valid drops, one REDIRECT bubble, next imem_addr=0x00, then pc_out=0x00. Also exeData=16'h0003 gives target 0x1C.
- exeOverride and imem_ready in the same cycle, with stall=1: the fetched word is never presented and the redirect is taken. rst asserted mid-stall: all outputs return to reset values next cycle.
- pc_out=0xFFFF_FFFC, sequential fetch: next imem_addr=0x0000_0000. Branch exeData=16'h0001 from 0xFFFF_FFFC gives target 0x0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage and its helpers.
//   fetch_state_e : fetch FSM states
//   PC_INC        : byte stride between sequential instructions
//   *_DEF         : default widths and reset PC used by fetch_unit
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      REDIRECT = 2'd2
   } fetch_state_e;

   localparam int unsigned ADDR_W_DEF   = 32;
   localparam int unsigned INSTR_W_DEF  = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/fetch_unit_branch_target.sv
// PC-relative target adder: target = pc + (sext(off) << 2), modulo 2^ADDR_W.
//   pc     : base byte address
//   off    : signed 16-bit word offset
//   target : resulting word-aligned byte address (given an aligned pc)
module branch_target #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [15:0]       off,
   output logic [ADDR_W-1:0] target
);

   logic [ADDR_W-1:0] off_ext;

   assign off_ext = {{(ADDR_W-16){off[15]}}, off};
   // The shift drops the top two bits, which keeps the sum modulo 2^ADDR_W.
   assign target  = pc + (off_ext << 2);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, fetches words from imem under a
// req/ready handshake and hands one instruction at a time to decode.
// A taken branch from execute squashes the held instruction and refetches
// from pc_out + (sext(exeData) << 2) after a one-cycle bubble.
//   clk, rst              : clock, synchronous active-high reset
//   exeOverride, exeData  : branch redirect and signed word offset
//   stall                 : downstream hold of instr_out/pc_out
//   imem_req/addr         : fetch request and word-aligned byte address
//   imem_ready/rdata      : fetch completion and returned instruction
//   instr_out/pc_out      : instruction presented to decode and its address
//   instr_valid           : instr_out/pc_out valid
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEF,
   parameter int unsigned       INSTR_W  = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               exeOverride,
   input  logic [15:0]        exeData,
   input  logic               stall,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               instr_valid
);

   fetch_state_e       state, state_nxt;
   logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nxt;
   logic [ADDR_W-1:0]  pc_nxt;
   logic [INSTR_W-1:0] instr_nxt;
   logic               valid_nxt;
   logic [ADDR_W-1:0]  br_target;
   logic               accept;
   logic               xfer;

   // Targets are relative to the instruction currently held at pc_out,
   // which is the branch execute is resolving.
   branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
      .pc     (pc_out),
      .off    (exeData),
      .target (br_target)
   );

   assign accept    = !instr_valid || !stall;
   // A redirect masks the request so the word returned this cycle is never
   // counted as a transfer.
   assign imem_req  = (state == FETCH) && accept && !exeOverride;
   assign imem_addr = fetch_pc;
   assign xfer      = imem_req && imem_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         pc_out      <= '0;
         instr_out   <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         pc_out      <= pc_nxt;
         instr_out   <= instr_nxt;
         instr_valid <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      pc_nxt       = pc_out;
      instr_nxt    = instr_out;
      valid_nxt    = instr_valid;

      if (exeOverride) begin
         // Highest priority: squash and retarget from any state.
         fetch_pc_nxt = br_target;
         valid_nxt    = 1'b0;
         state_nxt    = REDIRECT;
      end else begin
         unique case (state)
            IDLE:     state_nxt = FETCH;
            REDIRECT: state_nxt = FETCH;
            FETCH: begin
               if (xfer) begin
                  instr_nxt    = imem_rdata;
                  pc_nxt       = fetch_pc;
                  valid_nxt    = 1'b1;
                  fetch_pc_nxt = fetch_pc + ADDR_W'(PC_INC);
               end else if (accept) begin
                  valid_nxt = 1'b0;
               end
            end
            default:  state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] XK = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        exeOverride = 1'b0;
   logic [15:0] exeData = 16'h0000;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_valid;

   logic        ws_mode = 1'b0;
   logic        rdy_drv = 1'b1;
   int          wcnt = 0;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t q[$];

   fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .exeOverride (exeOverride),
      .exeData     (exeData),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instr_out   (instr_out),
      .pc_out      (pc_out),
      .instr_valid (instr_valid)
   );

   always #5 clk = ~clk;

   // Memory model: data is a function of the address; wait-state mode holds
   // ready low for two requesting cycles before each transfer.
   assign imem_rdata = imem_addr ^ XK;
   assign imem_ready = ws_mode ? (wcnt == 2) : rdy_drv;

   always @(posedge clk) begin
      if (imem_req && imem_ready) wcnt <= 0;
      else if (imem_req)          wcnt <= wcnt + 1;
   end

   function automatic void push(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = pc ^ XK;
      q.push_back(e);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Monitor: a presentation is new unless the previous cycle already held a
   // valid instruction under stall.
   logic prev_valid = 1'b0;
   logic prev_stall = 1'b0;
   always @(negedge clk) begin
      if (instr_valid === 1'b1 && !(prev_valid && prev_stall)) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_instr: pc_out %h instr_out %h with no expected entry", pc_out, instr_out);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (pc_out !== e.pc || instr_out !== e.instr) begin
               n_fail++;
               $display("FAIL instr_seq: got pc %h instr %h expected pc %h instr %h",
                        pc_out, instr_out, e.pc, e.instr);
            end
         end
      end
      prev_valid = (instr_valid === 1'b1);
      prev_stall = stall;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      // Reset
      repeat (2) tick();
      sample();
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_instr_out", instr_out, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      tick();
      rst = 1'b0;
      sample();
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
      tick();                                   // E1: IDLE -> FETCH
      sample();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      tick();                                   // E2
      sample();
      chk("seq_addr4", imem_addr, 32'h4);
      tick(); tick();                           // E4: pc_out=8
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("stall_pc", pc_out, 32'h8);
         chk("stall_instr", instr_out, 32'h8 ^ XK);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         tick();
      end
      stall = 1'b0;
      tick(); tick();                           // E9: pc_out=0x10
      exeOverride = 1'b1; exeData = 16'hFFFC;
      sample();
      chk("ovr_req_mask", {31'd0, imem_req}, 32'd0);
      tick();                                   // E10: redirect
      exeOverride = 1'b0;
      sample();
      chk("redir_valid", {31'd0, instr_valid}, 32'd0);
      chk("redir_req", {31'd0, imem_req}, 32'd0);
      chk("redir_addr", imem_addr, 32'h0);
      push(32'h0);
      tick();                                   // E11: back to FETCH
      sample();
      chk("refetch_req", {31'd0, imem_req}, 32'd1);
      chk("refetch_addr", imem_addr, 32'h0);
      tick();                                   // E12: pc_out=0
      ws_mode = 1'b1;
      push(32'h4); push(32'h8); push(32'hC);
      cnt = 0;
      for (int i = 0; i < 9; i++) begin
         sample();
         if (instr_valid === 1'b1) cnt++;
         if (i == 1 || i == 2) chk("ws_addr_hold", imem_addr, 32'h4);
         tick();
      end
      chk("ws_pulses", cnt, 32'd3);
      // E21+1: pc_out=C; stalled redirect racing a ready fetch
      ws_mode = 1'b0; rdy_drv = 1'b1; stall = 1'b1;
      tick();
      exeOverride = 1'b1; exeData = 16'h0003;
      sample();
      chk("combo_req", {31'd0, imem_req}, 32'd0);
      tick();                                   // E23
      exeOverride = 1'b0; stall = 1'b0;
      sample();
      chk("combo_valid", {31'd0, instr_valid}, 32'd0);
      chk("combo_target", imem_addr, 32'h18);
      push(32'h18);
      tick(); tick();                           // E25: pc_out=0x18
      exeOverride = 1'b1; exeData = 16'hFFFC;
      tick();                                   // E26: target 0x08
      exeData = 16'h0001;
      sample();
      chk("neg_target", imem_addr, 32'h08);
      chk("neg_valid", {31'd0, instr_valid}, 32'd0);
      tick();                                   // E27: retarget from held pc_out
      exeOverride = 1'b0;
      sample();
      chk("reretarget", imem_addr, 32'h1C);
      chk("reretarget_req", {31'd0, imem_req}, 32'd0);
      push(32'h1C);
      tick();                                   // E28
      sample();
      chk("rr_fetch_addr", imem_addr, 32'h1C);
      tick();                                   // E29: pc_out=0x1C
      stall = 1'b1;
      tick();                                   // E30
      rst = 1'b1;
      tick();                                   // E31: reset mid-stall
      rst = 1'b0; stall = 1'b0; exeOverride = 1'b1; exeData = 16'hFFFF;
      sample();
      chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst2_pc_out", pc_out, 32'd0);
      chk("rst2_instr", instr_out, 32'd0);
      chk("rst2_addr", imem_addr, 32'd0);
      chk("rst2_req", {31'd0, imem_req}, 32'd0);
      tick();                                   // E32: redirect from IDLE
      exeOverride = 1'b0;
      sample();
      chk("wrap_neg_target", imem_addr, 32'hFFFF_FFFC);
      push(32'hFFFF_FFFC);
      tick(); tick();                           // E34: pc_out=FFFFFFFC
      exeOverride = 1'b1; exeData = 16'h0001;
      sample();
      chk("wrap_seq_addr", imem_addr, 32'h0);
      tick();                                   // E35
      exeOverride = 1'b0;
      sample();
      chk("wrap_br_target", imem_addr, 32'h0);
      chk("wrap_br_valid", {31'd0, instr_valid}, 32'd0);
      push(32'h0); push(32'h4);
      tick(); tick(); tick();                   // E38: pc_out=4
      stall = 1'b1;
      repeat (3) tick();
      sample();
      chk("queue_drained", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
